// File: rtl/res_pkg.sv
// Shared types and sizes for the layer-4 residual FIFO.
package res_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int CHANNEL_NUM = 128;
    localparam int RES_CH      = CHANNEL_NUM / 2;
    localparam int DEPTH       = 16;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    typedef logic signed [DATA_WIDTH-1:0] res_word_t;
    typedef res_word_t [RES_CH-1:0]       res_vec_t;
    typedef res_word_t [CHANNEL_NUM-1:0]  out_vec_t;
    typedef logic [PTR_W-1:0]             ptr_t;
    typedef logic [CNT_W-1:0]             cnt_t;

    // Upper channels carry no residual and are always zero.
    function automatic out_vec_t widen(input res_vec_t v);
        out_vec_t o;
        o = '0;
        o[RES_CH-1:0] = v;
        return o;
    endfunction

endpackage

// File: rtl/res_fifo_ctrl.sv
// Pointer/count/flag control for the residual FIFO, data-width independent.
// RES_FIFO_FLUSH_EN adds a synchronous flush input.
module res_fifo_ctrl
    import res_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef RES_FIFO_FLUSH_EN
    input  logic flush,
`endif
    input  logic wr_valid,
    input  logic rd_req,
    output logic wr_ready,
    output logic wr_en,
    output logic rd_en,
    output ptr_t wr_ptr,
    output ptr_t rd_ptr,
    output cnt_t count,
    output logic overflow,
    output logic underflow
);

    logic full;
    logic empty;
    logic clr;
    logic wr_blk;

`ifdef RES_FIFO_FLUSH_EN
    assign clr    = rst || flush;
    assign wr_blk = flush;
`else
    assign clr    = rst;
    assign wr_blk = 1'b0;
`endif

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full || rd_req;
    assign wr_en    = wr_valid && wr_ready && !wr_blk;
    assign rd_en    = rd_req && !empty;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + ptr_t'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
            if (wr_valid && !wr_ready)
                overflow <= 1'b1;
            if (rd_req && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/res_fifo_layer4.sv
// Layer-4 residual FIFO: stores residual vectors and replays one per beat.
// RES_FIFO_FLUSH_EN adds a synchronous flush input.
module res_fifo_layer4
    import res_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
`ifdef RES_FIFO_FLUSH_EN
    input  logic     flush,
`endif
    input  logic     wr_valid,
    input  res_vec_t wr_data,
    output logic     wr_ready,
    input  logic     rd_req,
    output out_vec_t res_out,
    output logic     res_out_valid,
    output cnt_t     count,
    output logic     overflow,
    output logic     underflow
);

    logic     wr_en;
    logic     rd_en;
    logic     clr;
    ptr_t     wr_ptr;
    ptr_t     rd_ptr;
    res_vec_t mem [DEPTH];

`ifdef RES_FIFO_FLUSH_EN
    assign clr = rst || flush;
`else
    assign clr = rst;
`endif

    res_fifo_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
`ifdef RES_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .wr_valid  (wr_valid),
        .rd_req    (rd_req),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Storage is not reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // Output holds between reads so the BN product stays stable.
    always_ff @(posedge clk) begin
        if (clr) begin
            res_out       <= '0;
            res_out_valid <= 1'b0;
        end else if (rd_req) begin
            if (rd_en) begin
                res_out       <= widen(mem[rd_ptr]);
                res_out_valid <= 1'b1;
            end else begin
                res_out       <= '0;
                res_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_res_fifo_layer4.sv
// Directed plus random bench for res_fifo_layer4 against a queue model.
// Define RES_FIFO_FLUSH_EN to exercise the flush input as well.
module tb_res_fifo_layer4;
    import res_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     flush;
    logic     wr_valid;
    res_vec_t wr_data;
    logic     wr_ready;
    logic     rd_req;
    out_vec_t res_out;
    logic     res_out_valid;
    cnt_t     count;
    logic     overflow;
    logic     underflow;

    int checks = 0;
    int errors = 0;

    res_vec_t q[$];
    out_vec_t m_out;
    logic     m_vld;
    logic     m_ovf;
    logic     m_unf;

    always #5 clk = ~clk;

    res_fifo_layer4 dut (
        .clk           (clk),
        .rst           (rst),
`ifdef RES_FIFO_FLUSH_EN
        .flush         (flush),
`endif
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_req        (rd_req),
        .res_out       (res_out),
        .res_out_valid (res_out_valid),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    function automatic res_vec_t pat(input int base, input bit inc);
        res_vec_t v;
        for (int k = 0; k < RES_CH; k++)
            v[k] = res_word_t'(base + (inc ? k : 0));
        return v;
    endfunction

    function automatic res_vec_t rnd_vec();
        res_vec_t v;
        for (int k = 0; k < RES_CH; k++)
            v[k] = res_word_t'($urandom);
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input out_vec_t obs,
                           input out_vec_t exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int k = CHANNEL_NUM - 1; k >= 0; k--)
                if (obs[k] !== exp[k])
                    bad = k;
            $error("FAIL %s ch%0d obs=%0h exp=%0h",
                   tag, bad, obs[bad], exp[bad]);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/count"}, int'(count), q.size());
        chk({tag, "/valid"}, int'(res_out_valid), int'(m_vld));
        chk({tag, "/ovf"}, int'(overflow), int'(m_ovf));
        chk({tag, "/unf"}, int'(underflow), int'(m_unf));
        chk_vec({tag, "/res"}, res_out, m_out);
    endtask

    task automatic model_clear();
        q.delete();
        m_out = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk_all("reset");
    endtask

    // One clock: check wr_ready, update the model, check outputs after edge.
    task automatic step(input logic wv, input res_vec_t wd,
                        input logic rr, input string tag);
        logic rdy;
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rr;
        #1;
        rdy = (q.size() != DEPTH) || rr;
        chk({tag, "/rdy"}, int'(wr_ready), int'(rdy));
        if (rr) begin
            if (q.size() > 0) begin
                m_out = widen(q.pop_front());
                m_vld = 1'b1;
            end else begin
                m_out = '0;
                m_vld = 1'b0;
                m_unf = 1'b1;
            end
        end
        if (wv) begin
            if (rdy)
                q.push_back(wd);
            else
                m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk_all(tag);
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++)
            step(1'b1, pat(base + i, 1'b0), 1'b0, "fill");
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        wr_data  = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Read on empty after reset
        step(1'b0, '0, 1'b1, "unf0");
        chk("unf0/flag", int'(underflow), 1);

        // Two writes, one read, then hold
        step(1'b1, pat(100, 1'b1), 1'b0, "w100");
        step(1'b1, pat(200, 1'b1), 1'b0, "w200");
        step(1'b0, '0, 1'b1, "r100");
        chk("r100/ch5", int'(res_out[5]), 105);
        chk("r100/ch70", int'(res_out[70]), 0);
        chk("r100/cnt", int'(count), 1);
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b0, "hold");
        chk("hold/ch5", int'(res_out[5]), 105);

        // Fill, overflow, then simultaneous read+write on full
        do_reset();
        fill(DEPTH, 0);
        step(1'b1, pat(55, 1'b0), 1'b0, "ovf");
        chk("ovf/flag", int'(overflow), 1);
        chk("ovf/cnt", int'(count), DEPTH);
        step(1'b1, pat(99, 1'b0), 1'b1, "fullrw");
        chk("fullrw/ch0", int'(res_out[0]), 0);
        chk("fullrw/cnt", int'(count), DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1, "drain");
            chk("drain/ch3", int'(res_out[3]), (i == DEPTH) ? 99 : i);
        end
        chk("drain/cnt", int'(count), 0);

        // Empty + read + write: no bypass
        step(1'b1, pat(7, 1'b0), 1'b1, "emptyrw");
        chk("emptyrw/valid", int'(res_out_valid), 0);
        chk("emptyrw/cnt", int'(count), 1);
        step(1'b0, '0, 1'b1, "r7");
        chk("r7/ch63", int'(res_out[63]), 7);

        // Reset mid-stream
        fill(9, 30);
        chk("pre_rst/cnt", int'(count), 9);
        do_reset();
        step(1'b0, '0, 1'b1, "post_rst");
        chk("post_rst/unf", int'(underflow), 1);

`ifdef RES_FIFO_FLUSH_EN
        fill(5, 40);
        step(1'b0, '0, 1'b1, "pre_fl");
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = pat(77, 1'b0);
        rd_req   = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        model_clear();
        chk_all("flush");
`endif

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), rnd_vec(),
                 ($urandom_range(0, 99) < 45), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
